// File: rtl/alu_pkg.sv
// Shared definitions for the SAP-1 adder/subtractor slice.
//   DATA_W   : datapath width (accumulator, B register, bus)
//   NIBBLE_W : width of one cascaded nibble adder stage
//   ADD/SUB  : encoding of the S_U operation select
package alu_pkg;
    localparam int   DATA_W   = 8;
    localparam int   NIBBLE_W = 4;
    localparam logic ADD      = 1'b0;
    localparam logic SUB      = 1'b1;
endpackage

// File: rtl/nibble_adder_4b.sv
// 4-bit ripple-carry adder, the building block cascaded twice to form the
// 8-bit sum (one per 74LS83-style nibble).
// Ports:
//   a, b  : nibble operands
//   cin   : carry into bit 0
//   s     : nibble sum
//   cout  : carry out of bit 3
module nibble_adder_4b
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic carry;

    // Carry is carried in a loop variable rather than a vector so the chain
    // stays a simple ripple without a self-referencing net.
    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/alu_add_sub.sv
// SAP-1 8-bit two's-complement adder/subtractor with tri-state bus driver.
// Subtraction is A + ~B + 1: S_U both inverts B and feeds the low nibble's
// carry-in. The final carry c8 = 1 means "no borrow" when subtracting.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   -> carry_out / zero_flag ports and the flag register exist;
//                flags load on rising CLK while E_U=1, else hold.
//   undefined -> block is purely combinational; CLK / CLR_n unused.
//
// Ports:
//   CLK         : clock for the flag register
//   CLR_n       : asynchronous active-low clear of the flags
//   a_input     : operand A (accumulator)
//   b_input     : operand B (B register)
//   S_U         : 0 = add, 1 = subtract
//   E_U         : 1 drives bus_output, 0 releases it to Z
//   bus_output  : result or high-impedance
//   carry_out   : registered c8            (ALU_FLAGS_EN only)
//   zero_flag   : registered result == 0   (ALU_FLAGS_EN only)
module alu_add_sub
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic [DATA_W-1:0] a_input,
    input  logic [DATA_W-1:0] b_input,
    input  logic              S_U,
    input  logic              E_U,
    output logic [DATA_W-1:0] bus_output
`ifdef ALU_FLAGS_EN
    ,
    output logic              carry_out,
    output logic              zero_flag
`endif
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] result;
    logic              c4;
    logic              c8;

    assign b_eff = b_input ^ {DATA_W{S_U != ADD}};

    nibble_adder_4b u_low (
        .a    (a_input[NIBBLE_W-1:0]),
        .b    (b_eff[NIBBLE_W-1:0]),
        .cin  (S_U == SUB),
        .s    (result[NIBBLE_W-1:0]),
        .cout (c4)
    );

    nibble_adder_4b u_high (
        .a    (a_input[DATA_W-1:NIBBLE_W]),
        .b    (b_eff[DATA_W-1:NIBBLE_W]),
        .cin  (c4),
        .s    (result[DATA_W-1:NIBBLE_W]),
        .cout (c8)
    );

    // Both nibbles share the single enable, as on the 74LS126 pair.
    assign bus_output = E_U ? result : {DATA_W{1'bz}};

`ifdef ALU_FLAGS_EN
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            carry_out <= 1'b0;
            zero_flag <= 1'b0;
        end else if (E_U) begin
            carry_out <= c8;
            zero_flag <= (result == '0);
        end
    end
`else
    // Flag register is not built; keep the clock, clear and c8 visibly parked.
    logic unused_flag_inputs;
    assign unused_flag_inputs = &{1'b0, CLK, CLR_n, c8};
`endif

endmodule

// File: tb/tb_alu_add_sub.sv
// Self-checking bench for alu_add_sub: directed cases with literal expectations,
// then a randomized sweep compared every cycle against an arithmetic model.
module tb_alu_add_sub;

    logic       CLK;
    logic       CLR_n;
    logic [7:0] a_input;
    logic [7:0] b_input;
    logic       S_U;
    logic       E_U;
    wire  [7:0] bus_output;
`ifdef ALU_FLAGS_EN
    logic       carry_out;
    logic       zero_flag;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    alu_add_sub dut (
        .CLK        (CLK),
        .CLR_n      (CLR_n),
        .a_input    (a_input),
        .b_input    (b_input),
        .S_U        (S_U),
        .E_U        (E_U),
        .bus_output (bus_output)
`ifdef ALU_FLAGS_EN
        ,
        .carry_out  (carry_out),
        .zero_flag  (zero_flag)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference arithmetic straight from the operation's definition.
    function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic s);
        int r;
        r = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return 8'(r & 255);
    endfunction

    function automatic logic ref_carry(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) return (a >= b);
        return ((int'(a) + int'(b)) > 255);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Released bus: Z in a four-state simulator, all-zero where Z resolves to 0.
    task automatic check_off(input string name, input logic [7:0] act);
        n_checks++;
        if (act === 8'bz || act === 8'h00) n_pass++;
        else $display("FAIL %s: got %b expected zzzzzzzz", name, act);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic e);
        @(posedge CLK);
        #2;
        a_input = a;
        b_input = b;
        S_U     = s;
        E_U     = e;
    endtask

`ifdef ALU_FLAGS_EN
    logic m_carry;
    logic m_zero;

    always @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            m_carry <= 1'b0;
            m_zero  <= 1'b0;
        end else if (E_U) begin
            m_carry <= ref_carry(a_input, b_input, S_U);
            m_zero  <= (ref_result(a_input, b_input, S_U) == 8'd0);
        end
    end
`endif

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            if (E_U) check8("bus_model", bus_output, ref_result(a_input, b_input, S_U));
            else     check_off("bus_model_off", bus_output);
`ifdef ALU_FLAGS_EN
            check1("carry_model", carry_out, m_carry);
            check1("zero_model", zero_flag, m_zero);
`endif
        end
    end

    initial begin
        CLR_n   = 1'b0;
        a_input = 8'd0;
        b_input = 8'd0;
        S_U     = 1'b0;
        E_U     = 1'b0;
        #1;
`ifdef ALU_FLAGS_EN
        check1("reset_carry", carry_out, 1'b0);
        check1("reset_zero", zero_flag, 1'b0);
`endif
        #11;
        CLR_n  = 1'b1;
        chk_en = 1'b1;

        drive(8'd128, 8'd32, 1'b0, 1'b1); #1;
        check8("add_128_32", bus_output, 8'd160);
        @(posedge CLK); #1;
`ifdef ALU_FLAGS_EN
        check1("add_128_32_carry", carry_out, 1'b0);
        check1("add_128_32_zero", zero_flag, 1'b0);
`endif

        drive(8'd200, 8'd32, 1'b0, 1'b1); #1;
        check8("add_200_32", bus_output, 8'd232);
        drive(8'd200, 8'd32, 1'b1, 1'b1); #1;
        check8("sub_200_32", bus_output, 8'd168);
        @(posedge CLK); #1;
`ifdef ALU_FLAGS_EN
        check1("sub_200_32_carry", carry_out, 1'b1);
`endif

        drive(8'd32, 8'd128, 1'b1, 1'b1); #1;
        check8("sub_32_128_wrap", bus_output, 8'd160);
        @(posedge CLK); #1;
`ifdef ALU_FLAGS_EN
        check1("sub_32_128_carry", carry_out, 1'b0);
`endif

        drive(8'd255, 8'd1, 1'b0, 1'b1); #1;
        check8("add_255_1", bus_output, 8'd0);
        @(posedge CLK); #1;
`ifdef ALU_FLAGS_EN
        check1("add_255_1_carry", carry_out, 1'b1);
        check1("add_255_1_zero", zero_flag, 1'b1);
`endif

        drive(8'd1, 8'd1, 1'b0, 1'b0); #1;
        check_off("bus_released", bus_output);
        @(posedge CLK); #1;
`ifdef ALU_FLAGS_EN
        check1("hold_carry", carry_out, 1'b1);
        check1("hold_zero", zero_flag, 1'b1);
`endif

        drive(8'd3, 8'd4, 1'b0, 1'b1); #1;
        CLR_n = 1'b0;
        #1;
`ifdef ALU_FLAGS_EN
        check1("clr_carry", carry_out, 1'b0);
        check1("clr_zero", zero_flag, 1'b0);
`endif
        check8("clr_bus", bus_output, 8'd7);
        #1;
        CLR_n = 1'b1;

        drive(8'd15, 8'd1, 1'b0, 1'b1); #1;
        check8("nibble_carry_15_1", bus_output, 8'd16);

        for (int i = 0; i < 400; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
